// File: rtl/wb_select_stage.sv
// Write-back source selector: picks one of NSRC sources per beat, tags it with the destination address.
// Latency: 1 cycle from accept to out_* when empty; 1 beat/cycle sustained while out_ready=1.
// Backpressure: 2-entry skid (main + skid); in_ready is registered and drops only when both entries are full.
module wb_select_stage #(
  parameter int DATA_W = 8,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NSRC*DATA_W-1:0] src_data,
  input  logic [SEL_W-1:0]       sel,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [DATA_W-1:0]      out_data,
  output logic [ADDR_W-1:0]      out_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   sel_err
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t             state;
  logic [DATA_W-1:0]  hold_q;
  logic [DATA_W-1:0]  skid_data;
  logic [ADDR_W-1:0]  skid_addr;
  logic               skid_err;

  logic [DATA_W-1:0]  cand;
  logic               legal;
  logic [DATA_W-1:0]  beat_data;
  logic               accept;
  logic               emit;

  // Select is compared unsigned; anything at or above NSRC is illegal.
  assign legal = (32'(sel) < 32'(NSRC));

  // Source mux over the populated slices only; unused select codes fall to zero here
  // and are replaced by the hold value below.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) cand = src_data[i*DATA_W +: DATA_W];
    end
  end

  assign beat_data = legal ? cand : hold_q;
  assign accept    = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // Pipeline FSM: main entry drives the outputs, skid parks one beat during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_addr  <= '0;
      sel_err   <= 1'b0;
      skid_data <= '0;
      skid_addr <= '0;
      skid_err  <= 1'b0;
      hold_q    <= '0;
    end else begin
      // The hold value tracks every legal accept, including one discarded by flush.
      if (accept && legal) hold_q <= cand;

      if (flush) begin
        // Drop everything; out_data/out_addr keep their last value.
        state     <= EMPTY;
        out_valid <= 1'b0;
        in_ready  <= 1'b1;
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              out_data  <= beat_data;
              out_addr  <= in_addr;
              sel_err   <= !legal;
              out_valid <= 1'b1;
              state     <= ONE;
            end
          end
          ONE: begin
            if (accept && emit) begin
              out_data <= beat_data;
              out_addr <= in_addr;
              sel_err  <= !legal;
            end else if (accept) begin
              skid_data <= beat_data;
              skid_addr <= in_addr;
              skid_err  <= !legal;
              in_ready  <= 1'b0;
              state     <= TWO;
            end else if (emit) begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end
          TWO: begin
            if (emit) begin
              out_data <= skid_data;
              out_addr <= skid_addr;
              sel_err  <= skid_err;
              in_ready <= 1'b1;
              state    <= ONE;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed bench for wb_select_stage: table of cycle vectors on a 4-source build,
// a sequence on a 3-source build for illegal selects, and an async reset during a stall.
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // 4-source instance
  logic [31:0] src;
  logic [1:0]  sel;
  logic [2:0]  in_addr;
  logic        in_valid, in_ready, flush, out_valid, out_ready, sel_err;
  logic [7:0]  out_data;
  logic [2:0]  out_addr;

  // 3-source instance
  logic [23:0] src3;
  logic [1:0]  sel3;
  logic [2:0]  in_addr3;
  logic        in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
  logic [7:0]  out_data3;
  logic [2:0]  out_addr3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  wb_select_stage #(.DATA_W(8), .NSRC(4), .SEL_W(2), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .src_data(src), .sel(sel), .in_addr(in_addr),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  wb_select_stage #(.DATA_W(8), .NSRC(3), .SEL_W(2), .ADDR_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .src_data(src3), .sel(sel3), .in_addr(in_addr3),
    .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
    .out_data(out_data3), .out_addr(out_addr3), .out_valid(out_valid3),
    .out_ready(out_ready3), .sel_err(sel_err3)
  );

  typedef struct {
    logic [31:0] src;
    logic [1:0]  sel;
    logic [2:0]  addr;
    logic        iv;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [7:0]  ed;
    logic [2:0]  ea;
    logic        ee;
    logic        er;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs -> expected state after the next edge
    //         src           sel   addr  iv    ordy  fl      ev    data    addr  err   in_rdy
    vt[0]  = '{32'h0000003C, 2'd0, 3'd5, 1'b1, 1'b1, 1'b0,   1'b1, 8'h3C, 3'd5, 1'b0, 1'b1};
    vt[1]  = '{32'h00000011, 2'd0, 3'd1, 1'b1, 1'b1, 1'b0,   1'b1, 8'h11, 3'd1, 1'b0, 1'b1};
    vt[2]  = '{32'h00002200, 2'd1, 3'd2, 1'b1, 1'b1, 1'b0,   1'b1, 8'h22, 3'd2, 1'b0, 1'b1};
    vt[3]  = '{32'h00330000, 2'd2, 3'd3, 1'b1, 1'b1, 1'b0,   1'b1, 8'h33, 3'd3, 1'b0, 1'b1};
    vt[4]  = '{32'h00000000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0,   1'b0, 8'h33, 3'd3, 1'b0, 1'b1};
    vt[5]  = '{32'h000000A1, 2'd0, 3'd4, 1'b1, 1'b0, 1'b0,   1'b1, 8'hA1, 3'd4, 1'b0, 1'b1};
    vt[6]  = '{32'h0000B200, 2'd1, 3'd6, 1'b1, 1'b0, 1'b0,   1'b1, 8'hA1, 3'd4, 1'b0, 1'b0};
    vt[7]  = '{32'h000000FF, 2'd0, 3'd0, 1'b1, 1'b0, 1'b0,   1'b1, 8'hA1, 3'd4, 1'b0, 1'b0};
    vt[8]  = '{32'h00000000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0,   1'b1, 8'hB2, 3'd6, 1'b0, 1'b1};
    vt[9]  = '{32'h00000000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0,   1'b0, 8'hB2, 3'd6, 1'b0, 1'b1};
    vt[10] = '{32'h44332211, 2'd3, 3'd7, 1'b1, 1'b1, 1'b0,   1'b1, 8'h44, 3'd7, 1'b0, 1'b1};
    vt[11] = '{32'h00000000, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0,   1'b1, 8'h44, 3'd7, 1'b0, 1'b1};
    vt[12] = '{32'h000000C1, 2'd0, 3'd1, 1'b1, 1'b0, 1'b0,   1'b1, 8'h44, 3'd7, 1'b0, 1'b0};
    vt[13] = '{32'h000000FF, 2'd0, 3'd2, 1'b1, 1'b0, 1'b1,   1'b0, 8'h44, 3'd7, 1'b0, 1'b1};
    vt[14] = '{32'h00000000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0,   1'b0, 8'h44, 3'd7, 1'b0, 1'b1};
    vt[15] = '{32'h000000D5, 2'd0, 3'd2, 1'b1, 1'b1, 1'b0,   1'b1, 8'hD5, 3'd2, 1'b0, 1'b1};
    vt[16] = '{32'h0000E600, 2'd1, 3'd3, 1'b1, 1'b1, 1'b1,   1'b0, 8'hD5, 3'd2, 1'b0, 1'b1};
    vt[17] = '{32'h00000000, 2'd0, 3'd0, 1'b0, 1'b1, 1'b0,   1'b0, 8'hD5, 3'd2, 1'b0, 1'b1};

    src = '0; sel = '0; in_addr = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    src3 = '0; sel3 = '0; in_addr3 = '0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_addr",  32'(out_addr),  32'd0);
    chk("rst_sel_err",   32'(sel_err),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Table-driven cycle vectors on the 4-source build
    for (int i = 0; i < NV; i++) begin
      src = vt[i].src; sel = vt[i].sel; in_addr = vt[i].addr;
      in_valid = vt[i].iv; out_ready = vt[i].ordy; flush = vt[i].fl;
      tick();
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vt[i].ed));
      chk($sformatf("v%0d_out_addr", i),  32'(out_addr),  32'(vt[i].ea));
      chk($sformatf("v%0d_sel_err", i),   32'(sel_err),   32'(vt[i].ee));
      chk($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vt[i].er));
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // 3-source build: illegal select replays the last legal value
    out_ready3 = 1'b1;
    in_valid3 = 1'b1; sel3 = 2'd3; in_addr3 = 3'd1; src3 = 24'h000000;
    tick();
    chk("n3_a_valid", 32'(out_valid3), 32'd1);
    chk("n3_a_data",  32'(out_data3),  32'h00);
    chk("n3_a_err",   32'(sel_err3),   32'd1);
    sel3 = 2'd1; in_addr3 = 3'd2; src3 = 24'h005A00;
    tick();
    chk("n3_b_data", 32'(out_data3), 32'h5A);
    chk("n3_b_err",  32'(sel_err3),  32'd0);
    sel3 = 2'd3; in_addr3 = 3'd3; src3 = 24'hEEEEEE;
    tick();
    chk("n3_c_data", 32'(out_data3), 32'h5A);
    chk("n3_c_addr", 32'(out_addr3), 32'd3);
    chk("n3_c_err",  32'(sel_err3),  32'd1);
    sel3 = 2'd2; in_addr3 = 3'd4; src3 = 24'h770000;
    tick();
    chk("n3_d_data", 32'(out_data3), 32'h77);
    chk("n3_d_err",  32'(sel_err3),  32'd0);
    // Flushed beat is discarded but its legal data still lands in the hold register
    sel3 = 2'd0; in_addr3 = 3'd5; src3 = 24'h000099; flush3 = 1'b1;
    tick();
    chk("n3_e_valid", 32'(out_valid3), 32'd0);
    chk("n3_e_data",  32'(out_data3),  32'h77);
    chk("n3_e_rdy",   32'(in_ready3),  32'd1);
    flush3 = 1'b0; sel3 = 2'd3; in_addr3 = 3'd6; src3 = 24'h111111;
    tick();
    chk("n3_f_valid", 32'(out_valid3), 32'd1);
    chk("n3_f_data",  32'(out_data3),  32'h99);
    chk("n3_f_err",   32'(sel_err3),   32'd1);
    in_valid3 = 1'b0;

    // Async reset while stalled in the two-entry state
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; in_addr = 3'd1; src = 32'h00000012;
    tick();
    src = 32'h00000034; in_addr = 3'd2;
    tick();
    in_valid = 1'b0;
    chk("stall_in_ready",  32'(in_ready),  32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    chk("stall_out_data",  32'(out_data),  32'h12);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_out_data",  32'(out_data),  32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("arst_no_beats", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
